// File: rtl/predictor_upd_ctrl_pkg.sv
// Shared definitions for the branch-predictor update controller: FSM state
// encodings and default sizing parameters.
package predictor_upd_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_DRAIN    = 2'd1;
    localparam state_t ST_QUIESCED = 2'd2;

    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_UPD_DEPTH = 4;

    function automatic logic is_mispredict(input logic taken, input logic pred);
        return taken ^ pred;
    endfunction

endpackage

// File: rtl/predictor_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates ({idx, taken})
// until they can be written into the predictor array.
module predictor_upd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rptr_q];

    // Guards make an illegal push/pop harmless instead of corrupting pointers.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wr_data;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/predictor_upd_ctrl.sv
// Sequencing controller in front of the branch predictor: forwards lookups,
// queues EX resolutions into the write port, handles quiesce and statistics.
module predictor_upd_ctrl
    import predictor_upd_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM  = 256,
    parameter int ADDR_WIDTH = $clog2(ENTRY_NUM),
    parameter int UPD_DEPTH  = DEF_UPD_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  lkp_valid,
    input  logic [ADDR_WIDTH-1:0] lkp_idx,
    output logic                  lkp_rsp_valid,
    output logic                  lkp_pred_taken,
    output logic                  lkp_hist_valid,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [ADDR_WIDTH-1:0] res_idx,
    input  logic                  res_taken,
    input  logic                  res_pred,
    input  logic                  quiesce_req,
    output logic                  quiesce_ack,
    output logic [ADDR_WIDTH-1:0] predictor_raddr,
    output logic [ADDR_WIDTH-1:0] predictor_waddr,
    output logic                  predictor_wen,
    output logic                  branch_taken_ex,
    input  logic                  rec_10_entry_valid,
    input  logic                  predictor_rd_data,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  stat_lkp_cnt,
    output logic [CNT_WIDTH-1:0]  stat_hit_cnt,
    output logic [CNT_WIDTH-1:0]  stat_mispred_cnt
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0]  lkp_cnt_q, lkp_cnt_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic [ADDR_WIDTH:0]   fifo_head;

    // Lookup path: the read address holds its last value when idle.
    assign predictor_raddr = lkp_valid ? lkp_idx : raddr_q;
    assign lkp_rsp_valid   = rsp_valid_q;
    assign lkp_hist_valid  = rsp_valid_q && rec_10_entry_valid;
    assign lkp_pred_taken  = rsp_valid_q && rec_10_entry_valid && predictor_rd_data;

    always_comb begin
        raddr_d     = predictor_raddr;
        rsp_valid_d = lkp_valid;
    end

    assign res_ready       = !fifo_full && (state_q == ST_RUN);
    assign fifo_push       = res_valid && res_ready;
    assign predictor_wen   = !fifo_empty;
    assign predictor_waddr = fifo_head[ADDR_WIDTH:1];
    assign branch_taken_ex = fifo_head[0];
    assign quiesce_ack     = (state_q == ST_QUIESCED);

    predictor_upd_fifo #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .push      (fifo_push),
        .pop       (predictor_wen),
        .wr_data   ({res_idx, res_taken}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    // Abort of a drain takes precedence over completing it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (quiesce_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!quiesce_req)    state_d = ST_RUN;
                else if (fifo_empty) state_d = ST_QUIESCED;
            end
            ST_QUIESCED: begin
                if (!quiesce_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        lkp_cnt_d     = lkp_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (stat_clr) begin
            lkp_cnt_d     = '0;
            hit_cnt_d     = '0;
            mispred_cnt_d = '0;
        end else begin
            if (rsp_valid_q && (lkp_cnt_q != '1)) begin
                lkp_cnt_d = lkp_cnt_q + CNT_WIDTH'(1);
            end
            if (rsp_valid_q && rec_10_entry_valid && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
            end
            if (fifo_push && is_mispredict(res_taken, res_pred) && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stat_lkp_cnt     = lkp_cnt_q;
    assign stat_hit_cnt     = hit_cnt_q;
    assign stat_mispred_cnt = mispred_cnt_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q       <= ST_RUN;
            raddr_q       <= '0;
            rsp_valid_q   <= 1'b0;
            lkp_cnt_q     <= '0;
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            raddr_q       <= raddr_d;
            rsp_valid_q   <= rsp_valid_d;
            lkp_cnt_q     <= lkp_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_predictor_upd_ctrl.sv
// Directed self-checking bench for predictor_upd_ctrl (small counters so
// saturation is reachable in a short run).
module tb_predictor_upd_ctrl;

    localparam int AW = 8;
    localparam int CW = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic          lkp_valid;
    logic [AW-1:0] lkp_idx;
    logic          lkp_rsp_valid;
    logic          lkp_pred_taken;
    logic          lkp_hist_valid;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_idx;
    logic          res_taken;
    logic          res_pred;
    logic          quiesce_req;
    logic          quiesce_ack;
    logic [AW-1:0] predictor_raddr;
    logic [AW-1:0] predictor_waddr;
    logic          predictor_wen;
    logic          branch_taken_ex;
    logic          rec_10_entry_valid;
    logic          predictor_rd_data;
    logic          stat_clr;
    logic [CW-1:0] stat_lkp_cnt;
    logic [CW-1:0] stat_hit_cnt;
    logic [CW-1:0] stat_mispred_cnt;

    int total = 0;
    int bad   = 0;

    predictor_upd_ctrl #(
        .ENTRY_NUM (256),
        .UPD_DEPTH (4),
        .CNT_WIDTH (CW)
    ) dut (
        .cpu_clk            (cpu_clk),
        .cpu_rst            (cpu_rst),
        .lkp_valid          (lkp_valid),
        .lkp_idx            (lkp_idx),
        .lkp_rsp_valid      (lkp_rsp_valid),
        .lkp_pred_taken     (lkp_pred_taken),
        .lkp_hist_valid     (lkp_hist_valid),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_idx            (res_idx),
        .res_taken          (res_taken),
        .res_pred           (res_pred),
        .quiesce_req        (quiesce_req),
        .quiesce_ack        (quiesce_ack),
        .predictor_raddr    (predictor_raddr),
        .predictor_waddr    (predictor_waddr),
        .predictor_wen      (predictor_wen),
        .branch_taken_ex    (branch_taken_ex),
        .rec_10_entry_valid (rec_10_entry_valid),
        .predictor_rd_data  (predictor_rd_data),
        .stat_clr           (stat_clr),
        .stat_lkp_cnt       (stat_lkp_cnt),
        .stat_hit_cnt       (stat_hit_cnt),
        .stat_mispred_cnt   (stat_mispred_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic nextCycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input int li, input logic rv, input int ri,
                                 input logic rt, input logic rp, input logic qr, input logic sc);
        lkp_valid   = lv;
        lkp_idx     = AW'(li);
        res_valid   = rv;
        res_idx     = AW'(ri);
        res_taken   = rt;
        res_pred    = rp;
        quiesce_req = qr;
        stat_clr    = sc;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cpu_rst            = 1'b1;
        rec_10_entry_valid = 1'b0;
        predictor_rd_data  = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        cpu_rst = 1'b0;
        #2;

        $display("[TB] reset state");
        checkOutput("rst_rsp_valid", 32'(lkp_rsp_valid), 0);
        checkOutput("rst_pred", 32'(lkp_pred_taken), 0);
        checkOutput("rst_hist", 32'(lkp_hist_valid), 0);
        checkOutput("rst_ack", 32'(quiesce_ack), 0);
        checkOutput("rst_wen", 32'(predictor_wen), 0);
        checkOutput("rst_bte", 32'(branch_taken_ex), 0);
        checkOutput("rst_raddr", 32'(predictor_raddr), 0);
        checkOutput("rst_waddr", 32'(predictor_waddr), 0);
        checkOutput("rst_lkp_cnt", 32'(stat_lkp_cnt), 0);
        checkOutput("rst_mis_cnt", 32'(stat_mispred_cnt), 0);
        checkOutput("rst_ready", 32'(res_ready), 1);

        $display("[TB] lookup path");
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("lkp_raddr_fwd", 32'(predictor_raddr), 5);
        checkOutput("lkp_no_rsp_yet", 32'(lkp_rsp_valid), 0);
        nextCycle();
        rec_10_entry_valid = 1'b0;
        predictor_rd_data  = 1'b1;
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("lkp1_rsp", 32'(lkp_rsp_valid), 1);
        checkOutput("lkp1_hist", 32'(lkp_hist_valid), 0);
        checkOutput("lkp1_pred", 32'(lkp_pred_taken), 0);
        nextCycle();
        rec_10_entry_valid = 1'b1;
        predictor_rd_data  = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lkp2_rsp", 32'(lkp_rsp_valid), 1);
        checkOutput("lkp2_hist", 32'(lkp_hist_valid), 1);
        checkOutput("lkp2_pred", 32'(lkp_pred_taken), 1);
        checkOutput("lkp_raddr_hold", 32'(predictor_raddr), 5);
        nextCycle();
        checkOutput("lkp_idle_rsp", 32'(lkp_rsp_valid), 0);
        checkOutput("lkp_idle_pred", 32'(lkp_pred_taken), 0);
        checkOutput("lkp_idle_hist", 32'(lkp_hist_valid), 0);
        checkOutput("lkp_cnt", 32'(stat_lkp_cnt), 2);
        checkOutput("hit_cnt", 32'(stat_hit_cnt), 1);
        rec_10_entry_valid = 1'b0;
        predictor_rd_data  = 1'b0;

        $display("[TB] back-to-back resolutions");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 1, i, logic'(i % 2 == 0), logic'(i % 2 == 0), 0, 0);
            checkOutput("b2b_ready", 32'(res_ready), 1);
            if (i == 1) begin
                checkOutput("b2b_first_wen", 32'(predictor_wen), 0);
            end else begin
                checkOutput("b2b_wen", 32'(predictor_wen), 1);
                checkOutput("b2b_waddr", 32'(predictor_waddr), 32'(i - 1));
                checkOutput("b2b_taken", 32'(branch_taken_ex), 32'((i - 1) % 2 == 0));
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_last_wen", 32'(predictor_wen), 1);
        checkOutput("b2b_last_waddr", 32'(predictor_waddr), 6);
        checkOutput("b2b_last_taken", 32'(branch_taken_ex), 1);
        nextCycle();
        checkOutput("b2b_drained", 32'(predictor_wen), 0);
        checkOutput("b2b_no_mispred", 32'(stat_mispred_cnt), 0);

        $display("[TB] quiesce handshake");
        applyStimulus(0, 0, 1, 7, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 8, 0, 0, 1, 0);
        checkOutput("q_run_ready", 32'(res_ready), 1);
        checkOutput("q_wen7", 32'(predictor_wen), 1);
        checkOutput("q_waddr7", 32'(predictor_waddr), 7);
        nextCycle();
        applyStimulus(0, 0, 1, 9, 0, 0, 1, 0);
        checkOutput("q_drain_ready", 32'(res_ready), 0);
        checkOutput("q_wen8", 32'(predictor_wen), 1);
        checkOutput("q_waddr8", 32'(predictor_waddr), 8);
        checkOutput("q_drain_ack", 32'(quiesce_ack), 0);
        nextCycle();
        checkOutput("q_empty_wen", 32'(predictor_wen), 0);
        checkOutput("q_empty_ack", 32'(quiesce_ack), 0);
        nextCycle();
        checkOutput("q_ack", 32'(quiesce_ack), 1);
        checkOutput("q_ack_ready", 32'(res_ready), 0);
        checkOutput("q_ack_wen", 32'(predictor_wen), 0);
        nextCycle();
        checkOutput("q_ack_hold", 32'(quiesce_ack), 1);
        applyStimulus(0, 0, 1, 9, 0, 0, 0, 0);
        checkOutput("q_ack_comb_hold", 32'(quiesce_ack), 1);
        nextCycle();
        checkOutput("q_release_ack", 32'(quiesce_ack), 0);
        checkOutput("q_release_ready", 32'(res_ready), 1);
        checkOutput("q_release_wen", 32'(predictor_wen), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("q_held_wen", 32'(predictor_wen), 1);
        checkOutput("q_held_waddr", 32'(predictor_waddr), 9);
        nextCycle();

        $display("[TB] mispredict counter");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 20 + i, 1, 0, 0, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 1, 23, 1, 0, 0, 1);
        checkOutput("mis_cnt3", 32'(stat_mispred_cnt), 3);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mis_clr", 32'(stat_mispred_cnt), 0);
        checkOutput("lkp_clr", 32'(stat_lkp_cnt), 0);
        checkOutput("hit_clr", 32'(stat_hit_cnt), 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 1, 30 + i, 0, 1, 0, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 1, 50, 1, 0, 0, 0);
        checkOutput("mis_at_max", 32'(stat_mispred_cnt), 15);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mis_saturated", 32'(stat_mispred_cnt), 15);
        nextCycle();

        $display("[TB] reset mid-operation");
        applyStimulus(0, 0, 1, 3, 1, 0, 1, 0);
        nextCycle();
        applyStimulus(1, 20, 1, 4, 1, 1, 1, 0);
        checkOutput("mr_pending_wen", 32'(predictor_wen), 1);
        checkOutput("mr_pending_waddr", 32'(predictor_waddr), 3);
        cpu_rst = 1'b1;
        nextCycle();
        cpu_rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mr_wen", 32'(predictor_wen), 0);
        checkOutput("mr_rsp_valid", 32'(lkp_rsp_valid), 0);
        checkOutput("mr_raddr", 32'(predictor_raddr), 0);
        checkOutput("mr_mis_cnt", 32'(stat_mispred_cnt), 0);
        checkOutput("mr_ready_run", 32'(res_ready), 1);
        checkOutput("mr_ack", 32'(quiesce_ack), 0);
        nextCycle();
        checkOutput("mr_still_empty", 32'(predictor_wen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
